segment_display_mux: RTL and testbench

Two-digit multiplexed seven-segment driver that sits directly downstream of the frequency counter. It captures the counter's tens/units BCD result on a one-cycle `load` strobe and holds it until the next strobe. It time-multiplexes the held digits onto one shared 7-bit segment bus plus a digit-select line, with optional leading-zero blanking, full blanking and a dash glyph for non-BCD values.

---
 rtl/segment_display_mux.sv | 85 ++++++++
 tb/tb_segment_display_mux.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_display_mux.sv
// Two-digit multiplexed seven-segment driver.
// Latches a tens/units BCD pair on a load strobe. It then alternates the two
// held digits onto a shared segment bus, with a digit-select line. It also
// supports leading-zero blanking, full blanking and a dash glyph for non-BCD
// values.
module segment_display_mux #(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  input  logic       blank_leading,
  input  logic       blank,
  output logic [6:0] segments,
  output logic       digit
);

  localparam int            CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  // Encoding is {g,f,e,d,c,b,a}. Values above 9 display a lone middle bar.
  function automatic logic [6:0] glyph(input logic [3:0] value);
    case (value)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  endfunction

  logic [CW-1:0] refresh_cnt;
  logic [3:0]    tens_hold;
  logic [3:0]    units_hold;
  logic          wrap;
  logic          digit_next;
  logic [3:0]    sel_val;
  logic [6:0]    seg_next;

  // Derive the next phase, then the glyph for that phase.
  // The glyph is looked up from the current hold values. A load on a phase
  // switch therefore appears one edge later. The glyph always matches the
  // digit select it is registered with.
  always_comb begin
    // NOTE: every signal gets a value on every path before any override, so
    // no latch is inferred.
    wrap       = (refresh_cnt == LAST);
    digit_next = digit ^ wrap;
    sel_val    = digit_next ? tens_hold : units_hold;
    seg_next   = glyph(sel_val);
    if (blank || (blank_leading && digit_next && (tens_hold == 4'd0))) begin
      seg_next = 7'h00;
    end
  end

  // Free-running refresh timing, registered outputs and the holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      digit       <= 1'b0;
      segments    <= 7'h00;
      tens_hold   <= 4'd0;
      units_hold  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge
      // values. This holds even where one register feeds another's next state.
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      digit       <= digit_next;
      segments    <= seg_next;
      if (load) begin
        tens_hold  <= ten_count;
        units_hold <= unit_count;
      end
    end
  end

endmodule

// File: tb/tb_segment_display_mux.sv
// Self-checking bench for segment_display_mux (REFRESH_DIV = 4).
// The reference model counts edges since reset release. From that count it
// derives the expected phase arithmetically. It looks up the expected glyph
// from a table.
module tb_segment_display_mux;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       blank_leading;
  logic       blank;
  logic [6:0] segments;
  logic       digit;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int         m_edges;
  logic [3:0] m_tens;
  logic [3:0] m_units;
  logic [6:0] glyph_tab [16];

  segment_display_mux #(.REFRESH_DIV(R)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (load),
    .ten_count     (ten_count),
    .unit_count    (unit_count),
    .blank_leading (blank_leading),
    .blank         (blank),
    .segments      (segments),
    .digit         (digit)
  );

  always #5 clk = ~clk;

  // Predicts the outputs of the coming edge, waits for it, then updates the
  // model and returns 1 ns after the edge.
  task automatic tick(output logic [6:0] e_seg, output logic e_dig);
    int         k;
    logic [3:0] sel;
    k     = m_edges + 1;
    e_dig = ((k / R) % 2) == 1;
    sel   = e_dig ? m_tens : m_units;
    if (blank || (blank_leading && e_dig && m_tens == 4'd0)) e_seg = 7'h00;
    else e_seg = glyph_tab[sel];
    @(posedge clk);
    if (load) begin
      m_tens  = ten_count;
      m_units = unit_count;
    end
    m_edges = k;
    #1;
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_tens  = 4'd0;
    m_units = 4'd0;
  endtask

  task automatic test_reset();
    logic [6:0] es;
    logic       ed;
    reset_n = 1'b0;
    load = 1'b0; ten_count = 4'd0; unit_count = 4'd0;
    blank_leading = 1'b0; blank = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (segments !== 7'h00 || digit !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: segments=%h digit=%b, expected 00/0", segments, digit);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (segments !== 7'h00 || digit !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held: segments=%h digit=%b, expected 00/0", segments, digit);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 2 * R; i++) begin
      tick(es, ed);
      tests_run++;
      if (segments !== es || digit !== ed) begin
        tests_failed++;
        $display("FAIL reset_idle edge %0d: segments=%h digit=%b, expected %h/%b",
                 i, segments, digit, es, ed);
      end
      if (i == 1 || i == R || i == 2 * R) begin
        tests_run++;
        if ((i == 1 && segments !== 7'h3F) || (i == R && digit !== 1'b1) ||
            (i == 2 * R && digit !== 1'b0)) begin
          tests_failed++;
          $display("FAIL reset_idle_fixed edge %0d: segments=%h digit=%b", i, segments, digit);
        end
      end
    end
  endtask

  task automatic test_load_basic();
    logic [6:0] es;
    logic       ed;
    // Wait until the phase about to come is a units phase, then load 4/2.
    while (((m_edges + 1) / R) % 2 != 0) tick(es, ed);
    load = 1'b1; ten_count = 4'd4; unit_count = 4'd2;
    tick(es, ed);
    load = 1'b0; ten_count = 4'd0; unit_count = 4'd0;
    for (int i = 0; i < 3 * R; i++) begin
      tick(es, ed);
      tests_run++;
      if (segments !== es || digit !== ed) begin
        tests_failed++;
        $display("FAIL load_4_2 step %0d: segments=%h digit=%b, expected %h/%b",
                 i, segments, digit, es, ed);
      end
      if (i == 0) begin
        tests_run++;
        if (segments !== 7'h5B) begin
          tests_failed++;
          $display("FAIL load_4_2_first: segments=%h, expected 5b", segments);
        end
      end
    end
  endtask

  task automatic test_leading_blank();
    logic [6:0] es;
    logic       ed;
    load = 1'b1; ten_count = 4'd0; unit_count = 4'd7; blank_leading = 1'b1;
    tick(es, ed);
    load = 1'b0;
    for (int i = 0; i < 4 * R; i++) begin
      if (i == 2 * R) blank_leading = 1'b0;
      tick(es, ed);
      tests_run++;
      if (segments !== es || digit !== ed) begin
        tests_failed++;
        $display("FAIL leading_blank step %0d bl=%b: segments=%h digit=%b, expected %h/%b",
                 i, blank_leading, segments, digit, es, ed);
      end
    end
  endtask

  task automatic test_blank_dash();
    logic [6:0] es;
    logic       ed;
    load = 1'b1; ten_count = 4'd12; unit_count = 4'd15;
    tick(es, ed);
    load = 1'b0;
    for (int i = 0; i < 6 * R; i++) begin
      blank = (i >= 2 * R && i < 4 * R);
      tick(es, ed);
      tests_run++;
      if (segments !== es || digit !== ed) begin
        tests_failed++;
        $display("FAIL blank_dash step %0d blank=%b: segments=%h digit=%b, expected %h/%b",
                 i, blank, segments, digit, es, ed);
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_load_on_switch();
    logic [6:0] es;
    logic       ed;
    load = 1'b1; ten_count = 4'd1; unit_count = 4'd1;
    tick(es, ed);
    load = 1'b0;
    // Advance until the coming edge is the 0 -> 1 phase switch.
    while (((m_edges + 1) % (2 * R)) != R) tick(es, ed);
    load = 1'b1; ten_count = 4'd9; unit_count = 4'd3;
    tick(es, ed);
    load = 1'b0;
    tests_run++;
    if (segments !== es || segments !== 7'h06 || digit !== 1'b1) begin
      tests_failed++;
      $display("FAIL switch_load_edge: segments=%h digit=%b, expected 06/1", segments, digit);
    end
    tick(es, ed);
    tests_run++;
    if (segments !== es || segments !== 7'h6F || digit !== 1'b1) begin
      tests_failed++;
      $display("FAIL switch_load_next: segments=%h digit=%b, expected 6f/1", segments, digit);
    end
  endtask

  task automatic test_random();
    logic [6:0] es;
    logic       ed;
    for (int i = 0; i < 300; i++) begin
      load          = ($urandom_range(3) == 0);
      ten_count     = 4'($urandom_range(15));
      unit_count    = 4'($urandom_range(15));
      blank         = ($urandom_range(9) == 0);
      blank_leading = ($urandom_range(1) == 0);
      tick(es, ed);
      tests_run++;
      if (segments !== es || digit !== ed) begin
        tests_failed++;
        $display("FAIL random step %0d: segments=%h digit=%b, expected %h/%b",
                 i, segments, digit, es, ed);
      end
    end
    load = 1'b0; blank = 1'b0; blank_leading = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] es;
    logic       ed;
    load = 1'b1; ten_count = 4'd8; unit_count = 4'd8;
    tick(es, ed);
    load = 1'b0;
    repeat (R + 1) tick(es, ed);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (segments !== 7'h00 || digit !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: segments=%h digit=%b, expected 00/0", segments, digit);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 2 * R; i++) begin
      tick(es, ed);
      tests_run++;
      if (segments !== es || digit !== ed || (i == 1 && segments !== 7'h3F)) begin
        tests_failed++;
        $display("FAIL reset_mid_release edge %0d: segments=%h digit=%b, expected %h/%b",
                 i, segments, digit, es, ed);
      end
    end
  endtask

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    test_reset();
    test_load_basic();
    test_leading_blank();
    test_blank_dash();
    test_load_on_switch();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
